if_id_skid_reg: RTL and testbench

- IF/ID pipeline register with a two-entry skid buffer.
- Sits between instruction fetch (PC register + instruction memory) and decode.
- Its imm_o output drives the 16-bit input of the sign-extension stage directly.
- Decouples fetch from decode stalls with a valid/ready handshake, so no instruction is lost or duplicated.
- Supports a flush for taken branches and jumps.

---
 rtl/if_id_skid_reg.sv | 109 ++++++++++
 tb/tb_if_id_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register backed by a two-entry skid buffer (main = head, skid = second).
// Define IF_ID_FLUSH_EN to let flush_i empty the buffer; otherwise flush_i is ignored.
module if_id_skid_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              flush_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [15:0]       imm_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] main_pc_reg, main_instr_reg;
  logic [DATA_W-1:0] skid_pc_reg, skid_instr_reg;
  logic              load_main_in, load_main_skid, load_skid;
  logic              acc, take;

  // Handshake flags come from registered state only, so ready never depends on dn_ready_i.
  assign up_ready_o = (state_reg != TWO);
  assign dn_valid_o = (state_reg != EMPTY);
  assign acc        = up_valid_i & up_ready_o;
  assign take       = dn_valid_o & dn_ready_i;

  assign pc_o    = main_pc_reg;
  assign instr_o = main_instr_reg;
  assign imm_o   = main_instr_reg[15:0];

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (acc) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && take) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (take) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
`ifdef IF_ID_FLUSH_EN
    // Flush wins over everything; held data is left in place since it is invalid anyway.
    if (flush_i) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
`endif
  end

`ifndef IF_ID_FLUSH_EN
  logic flush_unused;
  assign flush_unused = flush_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= EMPTY;
      main_pc_reg    <= '0;
      main_instr_reg <= '0;
      skid_pc_reg    <= '0;
      skid_instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main_in) begin
        main_pc_reg    <= pc_i;
        main_instr_reg <= instr_i;
      end else if (load_main_skid) begin
        main_pc_reg    <= skid_pc_reg;
        main_instr_reg <= skid_instr_reg;
      end
      if (load_skid) begin
        skid_pc_reg    <= pc_i;
        skid_instr_reg <= instr_i;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus random traffic
// compared against a FIFO-queue reference model (honours IF_ID_FLUSH_EN if defined).
module tb_if_id_skid_reg;

  logic        clk_i;
  logic        rst_i;
  logic        up_valid_i;
  logic        up_ready_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        dn_valid_o;
  logic        dn_ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [15:0] imm_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries are {pc, instr}, head is index 0, capacity two.
  logic [63:0] mq[$];

  if_id_skid_reg #(.DATA_W(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .up_valid_i (up_valid_i),
    .up_ready_o (up_ready_o),
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .flush_i    (flush_i),
    .dn_valid_o (dn_valid_o),
    .dn_ready_i (dn_ready_i),
    .pc_o       (pc_o),
    .instr_o    (instr_o),
    .imm_o      (imm_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    check("dn_valid", {31'd0, dn_valid_o}, {31'd0, mq.size() > 0});
    check("up_ready", {31'd0, up_ready_o}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      head = mq[0];
      check("pc", pc_o, head[63:32]);
      check("instr", instr_o, head[31:0]);
      check("imm", {16'd0, imm_o}, {16'd0, head[15:0]});
    end
  endtask

  // One clock cycle: drive inputs at posedge+1, check at posedge+3, advance the model on the edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    logic m_acc, m_take, m_flush;
    logic [63:0] head;
    up_valid_i = v;
    pc_i       = pc;
    instr_i    = ins;
    dn_ready_i = rdy;
    flush_i    = fl;
    #2;
    check_outputs();
    m_acc  = v && (mq.size() < 2);
    m_take = rdy && (mq.size() > 0);
`ifdef IF_ID_FLUSH_EN
    m_flush = fl;
`else
    m_flush = 1'b0;
`endif
    @(posedge clk_i);
    #1;
    if (m_flush) begin
      mq.delete();
      $display("flush");
    end else begin
      if (m_take) begin
        head = mq.pop_front();
        $display("xfer pc=%h instr=%h", head[63:32], head[31:0]);
      end
      if (m_acc) mq.push_back({pc, ins});
    end
  endtask

  initial begin
    rst_i      = 1'b0;
    up_valid_i = 1'b0;
    pc_i       = '0;
    instr_i    = '0;
    flush_i    = 1'b0;
    dn_ready_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset held low with random inputs
    for (int i = 0; i < 3; i++) begin
      up_valid_i = 1'($urandom);
      pc_i       = $urandom;
      instr_i    = $urandom;
      dn_ready_i = 1'($urandom);
      flush_i    = 1'($urandom);
      @(posedge clk_i);
      #1;
      check("rst_dn_valid", {31'd0, dn_valid_o}, 32'd0);
      check("rst_up_ready", {31'd0, up_ready_o}, 32'd1);
      check("rst_instr", instr_o, 32'd0);
      check("rst_imm", {16'd0, imm_o}, 32'd0);
      check("rst_pc", pc_o, 32'd0);
    end
    rst_i = 1'b1;

    // Streaming at full rate
    cycle(1'b1, 32'h0, 32'h2001_0005, 1'b1, 1'b0);
    cycle(1'b1, 32'h4, 32'h2002_FFFC, 1'b1, 1'b0);
    check("stream_imm0", {16'd0, imm_o}, 32'h0000_FFFC);
    cycle(1'b1, 32'h8, 32'h0022_1820, 1'b1, 1'b0);
    check("stream_imm2", {16'd0, imm_o}, 32'h0000_1820);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: decode blocked for three cycles while fetch keeps presenting
    cycle(1'b1, 32'h0, 32'h2001_0005, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, 32'h2002_FFFC, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 32'h0022_1820, 1'b0, 1'b0);
    check("stall_up_ready", {31'd0, up_ready_o}, 32'd0);
    check("stall_instr", instr_o, 32'h2001_0005);
    cycle(1'b1, 32'h8, 32'h0022_1820, 1'b1, 1'b0);
    check("stall_rel_instr", instr_o, 32'h2002_FFFC);
    cycle(1'b1, 32'h8, 32'h0022_1820, 1'b1, 1'b0);
    check("stall_rel_instr2", instr_o, 32'h0022_1820);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while holding two entries
    cycle(1'b1, 32'h10, 32'h1111_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 32'h2222_0002, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef IF_ID_FLUSH_EN
    check("flush_dn_valid", {31'd0, dn_valid_o}, 32'd0);
    check("flush_up_ready", {31'd0, up_ready_o}, 32'd1);
`endif
    cycle(1'b1, 32'h20, 32'h1000_0003, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush coinciding with an accept from EMPTY
    cycle(1'b1, 32'h30, 32'h3333_0003, 1'b0, 1'b1);
`ifdef IF_ID_FLUSH_EN
    check("flush_acc_dn_valid", {31'd0, dn_valid_o}, 32'd0);
`endif
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while full, between clock edges
    cycle(1'b1, 32'h50, 32'h5555_0005, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 32'h6666_0006, 1'b0, 1'b0);
    up_valid_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    check("arst_dn_valid", {31'd0, dn_valid_o}, 32'd0);
    check("arst_up_ready", {31'd0, up_ready_o}, 32'd1);
    check("arst_instr", instr_o, 32'd0);
    check("arst_pc", pc_o, 32'd0);
    mq.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cycle(1'b1, 32'h40, 32'h2003_0007, 1'b0, 1'b0);
    check("arst_first_instr", instr_o, 32'h2003_0007);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
